mdu_seq: RTL and testbench

Iterative multiply/divide unit with its own HI/LO register pair, sitting beside the ALU in the EX stage. It accepts MULT/MULTU/DIV/DIVU with a start pulse and computes over 33 cycles: 32 radix-2 iterations plus one sign-fix cycle. While running it holds `busy` so the pipeline can stall HI/LO consumers. It also serves MTHI/MTLO writes, and supports a flush for exceptions.

---
 rtl/mdu_seq_pkg.sv | 37 +++
 rtl/mdu_iter.sv | 49 ++++
 rtl/mdu_seq.sv | 195 +++++++++++++++++++
 tb/tb_mdu_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: shared encodings and helpers for the iterative multiply/divide
// unit.
//   - mdu_op_e    : MDU operation encodings (MULT, MULTU, DIV, DIVU)
//   - mdu_state_e : sequencer FSM states
//   - MDU_ITER    : iteration count, equal to the operand width
//   - mag32()     : conditional two's-complement negate, used both to take
//                   magnitudes and to re-apply signs
package mdu_seq_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

    localparam int MDU_ITER = 32;

    // Negate v when neg is set; 0x80000000 maps onto itself, which the
    // signed-overflow divide case relies on.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        logic [31:0] r;
        if (neg) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one combinational radix-2 step of the multiply or divide loop.
// Ports:
//   is_div   in  1   0 = shift-add multiply step, 1 = restoring divide step
//   acc      in  64  accumulator before the step
//   operand  in  32  multiplicand (multiply) or divisor (divide) magnitude
//   acc_next out 64  accumulator after the step
// Multiply: acc = {partial product, remaining multiplier bits}; add in the
// upper half when the low bit is set and shift right, keeping the carry.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits};
// shift left, compare the 33-bit remainder against the divisor, and shift
// the quotient bit in at the bottom.
module mdu_iter
    import mdu_seq_pkg::*;
(
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] sum_s;
    logic [32:0] rem_s;
    logic [31:0] diff_s;

    // Single multiply or divide step selected by is_div.
    always_comb begin
        sum_s    = 33'd0;
        rem_s    = acc[63:31];
        diff_s   = acc[62:31] - operand;
        acc_next = acc;
        if (is_div) begin
            // Remainder is below the divisor before the shift, so after a
            // successful subtract the difference always fits in 32 bits.
            if (rem_s >= {1'b0, operand}) begin
                acc_next = {diff_s, acc[30:0], 1'b1};
            end else begin
                acc_next = {rem_s[31:0], acc[30:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                sum_s = {1'b0, acc[63:32]} + {1'b0, operand};
            end else begin
                sum_s = {1'b0, acc[63:32]};
            end
            acc_next = {sum_s, acc[31:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide unit with its own HI/LO pair.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, op        begin MULT/MULTU/DIV/DIVU (sampled only while idle)
//   srca, srcb       rs / rt operands
//   mthi, mtlo, wdata  direct HI/LO writes (idle, no start)
//   flush            abort the in-flight operation without committing
//   busy, hi, lo     registered status and HI/LO outputs
// An operation occupies ITER iteration cycles plus one sign-fix cycle.
// Signed operands are reduced to magnitudes at start; signs are re-applied
// in the fix cycle. A zero divisor yields an all-ones quotient and the
// dividend as remainder by forcing the quotient sign positive.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int ITER = MDU_ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(ITER);

    mdu_state_e  state_r, state_nxt_s;
    mdu_op_e     op_r;
    logic [CW-1:0] cnt_r;
    logic [63:0] acc_r, acc_nxt_s;
    logic [31:0] opnd_r;
    logic        sign_q_r, sign_r_r;
    logic        busy_r;
    logic [31:0] hi_r, lo_r;

    logic        load_s, step_s, commit_s, wr_hi_s, wr_lo_s;
    logic        is_div_s, sa_s, sb_s;
    logic [31:0] maga_s, magb_s;
    logic [63:0] prod_neg_s;
    logic [31:0] hi_fix_s, lo_fix_s;

    mdu_iter u_iter (
        .is_div   (op_r[1]),
        .acc      (acc_r),
        .operand  (opnd_r),
        .acc_next (acc_nxt_s)
    );

    // Next-state and control decode for the sequencer.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        commit_s    = 1'b0;
        wr_hi_s     = 1'b0;
        wr_lo_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !flush) begin
                    state_nxt_s = ST_RUN;
                    load_s      = 1'b1;
                end else begin
                    // A start pulse (even one cancelled by flush) blocks writes.
                    wr_hi_s = mthi && !start;
                    wr_lo_s = mtlo && !start;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    step_s = 1'b1;
                    if (cnt_r == CW'(ITER - 1)) begin
                        state_nxt_s = ST_FIX;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_FIX: begin
                state_nxt_s = ST_IDLE;
                if (flush) begin
                    commit_s = 1'b0;
                end else begin
                    commit_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Operand magnitudes and signs; op[0] clear means a signed operation.
    always_comb begin
        is_div_s = op[1];
        sa_s     = srca[31] & ~op[0];
        sb_s     = srcb[31] & ~op[0];
        maga_s   = mag32(srca, sa_s);
        magb_s   = mag32(srcb, sb_s);
    end

    // Sign fix of the finished accumulator into HI/LO values.
    always_comb begin
        prod_neg_s = 64'd0 - acc_r;
        hi_fix_s   = acc_r[63:32];
        lo_fix_s   = acc_r[31:0];
        case (op_r)
            MDU_MULT, MDU_MULTU: begin
                if (sign_q_r) begin
                    hi_fix_s = prod_neg_s[63:32];
                    lo_fix_s = prod_neg_s[31:0];
                end else begin
                    hi_fix_s = acc_r[63:32];
                    lo_fix_s = acc_r[31:0];
                end
            end
            MDU_DIV, MDU_DIVU: begin
                hi_fix_s = mag32(acc_r[63:32], sign_r_r);
                lo_fix_s = mag32(acc_r[31:0], sign_q_r);
            end
            default: begin
                hi_fix_s = acc_r[63:32];
                lo_fix_s = acc_r[31:0];
            end
        endcase
    end

    // FSM state register and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Operation datapath: latch operands at start, iterate while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= MDU_MULT;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= 64'd0;
            opnd_r   <= 32'd0;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
        end else if (load_s) begin
            op_r     <= mdu_op_e'(op);
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {32'd0, (is_div_s ? maga_s : magb_s)};
            opnd_r   <= is_div_s ? magb_s : maga_s;
            // Zero divisor: keep the all-ones quotient unnegated.
            sign_q_r <= (sa_s ^ sb_s) & (|srcb);
            sign_r_r <= sa_s;
        end else if (step_s) begin
            cnt_r <= cnt_r + CW'(1);
            acc_r <= acc_nxt_s;
        end
    end

    // HI/LO architectural registers: operation commit or MTHI/MTLO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else begin
            if (commit_s) begin
                hi_r <= hi_fix_s;
                lo_r <= lo_fix_s;
            end else begin
                if (wr_hi_s) begin
                    hi_r <= wdata;
                end
                if (wr_lo_s) begin
                    lo_r <= wdata;
                end
            end
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic        clk, rst_n, start, mthi, mtlo, flush, busy;
    logic [1:0]  op;
    logic [31:0] srca, srcb, wdata, hi, lo;
    int pass_cnt = 0;
    int total_cnt = 0;

    mdu_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srca(srca),
        .srcb(srcb), .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
        .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Count negedges with busy high; stops at the first idle negedge.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
            else break;
        end
    endtask

    // Launch one operation (called at a negedge) and return observations.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int n, output logic [31:0] h, output logic [31:0] l);
        op = o; srca = a; srcb = b; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(n);
        h = hi; l = lo;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
        op = 2'b00; srca = 32'd0; srcb = 32'd0; wdata = 32'd0;
        #12;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs a table of operations and checks latency, HI and LO for each.
    task automatic run_table(input string tag, input logic [1:0] ops[], input logic [31:0] av[],
                             input logic [31:0] bv[], input logic [31:0] eh[], input logic [31:0] el[]);
        int n;
        logic [31:0] h, l;
        for (int i = 0; i < ops.size(); i++) begin
            do_op(ops[i], av[i], bv[i], n, h, l);
            total_cnt++; if (n !== 33) $display("FAIL %s[%0d]_cycles got %0d want 33", tag, i, n); else pass_cnt++;
            total_cnt++; if (h !== eh[i]) $display("FAIL %s[%0d]_hi got %h want %h", tag, i, h, eh[i]); else pass_cnt++;
            total_cnt++; if (l !== el[i]) $display("FAIL %s[%0d]_lo got %h want %h", tag, i, l, el[i]); else pass_cnt++;
        end
    endtask

    task automatic test_mult();
        logic [1:0]  ops[] = '{MDU_MULTU, MDU_MULT};
        logic [31:0] av[]  = '{32'hFFFFFFFF, 32'hFFFFFFFD};
        logic [31:0] bv[]  = '{32'hFFFFFFFF, 32'h00000007};
        logic [31:0] eh[]  = '{32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] el[]  = '{32'h00000001, 32'hFFFFFFEB};
        run_table("mult", ops, av, bv, eh, el);
    endtask

    task automatic test_div();
        logic [1:0]  ops[] = '{MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIV};
        logic [31:0] av[]  = '{32'hFFFFFFF9, 32'd5, 32'hFFFFFFFB, 32'h80000000};
        logic [31:0] bv[]  = '{32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
        logic [31:0] eh[]  = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFB, 32'd0};
        logic [31:0] el[]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        run_table("div", ops, av, bv, eh, el);
    endtask

    // Second op is launched in the very first idle cycle after the first.
    task automatic test_back_to_back();
        logic [1:0]  ops[] = '{MDU_DIVU, MDU_MULT};
        logic [31:0] av[]  = '{32'd100, 32'h80000000};
        logic [31:0] bv[]  = '{32'd7, 32'h80000000};
        logic [31:0] eh[]  = '{32'd2, 32'h40000000};
        logic [31:0] el[]  = '{32'd14, 32'd0};
        run_table("b2b", ops, av, bv, eh, el);
    endtask

    task automatic test_mthilo();
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BADF00D;
        @(posedge clk); #1 mthi = 1'b0; mtlo = 1'b0;
        @(negedge clk);
        total_cnt++; if (hi !== 32'h0BADF00D) $display("FAIL mthilo_both_hi got %h want 0badf00d", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h0BADF00D) $display("FAIL mthilo_both_lo got %h want 0badf00d", lo); else pass_cnt++;
        mthi = 1'b1; wdata = 32'h12345678;
        @(posedge clk); #1 mthi = 1'b0;
        @(negedge clk);
        total_cnt++; if (hi !== 32'h12345678) $display("FAIL mthi_hi got %h want 12345678", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h0BADF00D) $display("FAIL mthi_lo got %h want 0badf00d", lo); else pass_cnt++;
    endtask

    task automatic test_flush();
        op = MDU_MULTU; srca = 32'd3; srcb = 32'd4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL flush_pre_busy got %b want 1", busy); else pass_cnt++;
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (hi !== 32'h12345678) $display("FAIL flush_hi got %h want 12345678", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h0BADF00D) $display("FAIL flush_lo got %h want 0badf00d", lo); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [31:0] h, l;
        op = MDU_DIV; srca = 32'd100; srcb = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (hi !== 32'd0) $display("FAIL rstmid_hi got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd0) $display("FAIL rstmid_lo got %h want 0", lo); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        do_op(MDU_DIVU, 32'd9, 32'd3, n, h, l);
        total_cnt++; if (n !== 33) $display("FAIL rstmid_div_cycles got %0d want 33", n); else pass_cnt++;
        total_cnt++; if (h !== 32'd0) $display("FAIL rstmid_div_hi got %h want 0", h); else pass_cnt++;
        total_cnt++; if (l !== 32'd3) $display("FAIL rstmid_div_lo got %h want 3", l); else pass_cnt++;
    endtask

    task automatic test_start_collisions();
        int n;
        op = MDU_DIVU; srca = 32'd9; srcb = 32'd3; start = 1'b1;
        mtlo = 1'b1; wdata = 32'hDEADBEEF;
        @(posedge clk); #1 start = 1'b0; mtlo = 1'b0;
        @(negedge clk);
        total_cnt++; if (lo !== 32'd3) $display("FAIL start_mtlo_lo got %h want 3", lo); else pass_cnt++;
        repeat (4) @(negedge clk);
        // Second start plus MTHI while busy: both must be ignored.
        op = MDU_MULTU; srca = 32'd2; srcb = 32'd2; start = 1'b1;
        mthi = 1'b1; wdata = 32'h11111111;
        @(posedge clk); #1 start = 1'b0; mthi = 1'b0;
        wait_done(n);
        total_cnt++; if (n !== 28) $display("FAIL busy_start_cycles got %0d want 28", n); else pass_cnt++;
        total_cnt++; if (hi !== 32'd0) $display("FAIL busy_start_hi got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd3) $display("FAIL busy_start_lo got %h want 3", lo); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL busy_start_noqueue got %b want 0", busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_mthilo();
        test_flush();
        test_reset_mid();
        test_start_collisions();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
